// File: rtl/kim_counter_top.sv
// Programmable up-counter: a start pulse latches a terminal value, then cnt
// climbs from 0 to that value one step per clock and holds until restarted.
module kim_counter_top #(
  parameter int unsigned CNT_DATA_WIDTH = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CNT_DATA_WIDTH-1:0] cnt_val,
  output logic [CNT_DATA_WIDTH-1:0] cnt
);

  localparam logic [CNT_DATA_WIDTH-1:0] ONE = CNT_DATA_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state, state_nx;
  logic [CNT_DATA_WIDTH-1:0] target, target_nx;
  logic [CNT_DATA_WIDTH-1:0] cnt_nx;

  // rst_n is active-high despite its name
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state  <= IDLE;
      target <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nx;
      target <= target_nx;
      cnt    <= cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    target_nx = target;
    cnt_nx    = cnt;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          target_nx = cnt_val;
          cnt_nx    = '0;
          state_nx  = (cnt_val != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        // target is never zero in RUN, so target-1 cannot underflow
        if (cnt == target - ONE) begin
          cnt_nx   = target;
          state_nx = DONE;
        end else begin
          cnt_nx = cnt + ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_kim_counter_top.sv
// Directed bench for kim_counter_top; drives on negedge setup, samples on negedge
// after the relevant rising edge.
module tb_kim_counter_top;

  localparam int unsigned W = 7;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] cnt_val;
  logic [W-1:0] cnt;

  int checks = 0;
  int errors = 0;

  kim_counter_top #(.CNT_DATA_WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .cnt_val (cnt_val),
    .cnt     (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] exp);
    checks++;
    assert (cnt === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, cnt, exp);
    end
  endtask

  // Pulse start for one edge; returns at the negedge after the accepting edge E0.
  task automatic pulse(input logic [W-1:0] val);
    start   = 1'b1;
    cnt_val = val;
    @(negedge clk);
    start   = 1'b0;
    cnt_val = '0;
  endtask

  task automatic count_up(input string tag, input int unsigned n);
    for (int unsigned k = 1; k <= n; k++) begin
      @(negedge clk);
      check(tag, W'(k));
    end
  endtask

  task automatic hold(input string tag, input logic [W-1:0] v, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      check(tag, v);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    cnt_val = '0;

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b1;
    #1 check("reset_async", '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    hold("reset_idle", '0, 5);

    // Basic count to 100, then hold
    pulse(7'd100);
    check("basic_e0", '0);
    count_up("basic_run", 100);
    hold("basic_hold", 7'd100, 22);

    // Restart from DONE
    pulse(7'd5);
    check("restart_e0", '0);
    count_up("restart_run", 5);
    hold("restart_hold", 7'd5, 4);

    // start/cnt_val ignored during RUN
    pulse(7'd10);
    check("ign_e0", '0);
    count_up("ign_pre", 4);
    start   = 1'b1;
    cnt_val = 7'd3;
    @(negedge clk);
    check("ign_at5", 7'd5);
    start   = 1'b0;
    cnt_val = '0;
    for (int unsigned k = 6; k <= 10; k++) begin
      @(negedge clk);
      check("ign_run", W'(k));
    end
    hold("ign_hold", 7'd10, 5);

    // Zero terminal value: straight to DONE, stays 0
    pulse(7'd0);
    check("zero_e0", '0);
    hold("zero_hold", '0, 6);

    // All-ones terminal value: no wrap
    pulse(7'd127);
    check("max_e0", '0);
    count_up("max_run", 127);
    hold("max_hold", 7'd127, 10);

    // start held high: accepted again once DONE is reached
    start   = 1'b1;
    cnt_val = 7'd2;
    @(negedge clk); check("held_e0", 7'd0);
    @(negedge clk); check("held_e1", 7'd1);
    @(negedge clk); check("held_e2", 7'd2);
    @(negedge clk); check("held_e3", 7'd0);
    start   = 1'b0;
    cnt_val = '0;
    @(negedge clk); check("held_e4", 7'd1);
    hold("held_hold", 7'd2, 4);

    // Reset mid-run
    pulse(7'd50);
    check("mid_e0", '0);
    count_up("mid_run", 20);
    #2 rst_n = 1'b1;
    #1 check("mid_async", '0);
    @(negedge clk);
    check("mid_inreset", '0);
    rst_n   = 1'b0;
    cnt_val = 7'd9;
    hold("mid_after", '0, 5);
    cnt_val = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
